// File: rtl/fast_matrix_mult_3x3_pkg.sv
// Shared constants and packing helper for the 3x3 unsigned 8-bit matrix multiplier.
package fast_matrix_mult_3x3_pkg;

    localparam int DIM    = 3;
    localparam int ELEM_W = 8;
    localparam int PROD_W = 16;
    localparam int SUM_W  = 18;
    localparam int MAT_W  = DIM * DIM * ELEM_W;

    // Row-major, element (0,0) in the top byte: returns the LSB index of element (row, col).
    function automatic int elem_lsb(input int row, input int col);
        return MAT_W - ELEM_W * (DIM * row + col + 1);
    endfunction

endpackage

// File: rtl/fast_matrix_mult_3x3_dot3_pipe.sv
// Two-stage registered three-term unsigned dot product; output is the sum modulo 2^ELEM_W.
module dot3_pipe
    import fast_matrix_mult_3x3_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ELEM_W-1:0] a0,
    input  logic [ELEM_W-1:0] a1,
    input  logic [ELEM_W-1:0] a2,
    input  logic [ELEM_W-1:0] b0,
    input  logic [ELEM_W-1:0] b1,
    input  logic [ELEM_W-1:0] b2,
    output logic [ELEM_W-1:0] sum
);

    logic [PROD_W-1:0] p0_r;
    logic [PROD_W-1:0] p1_r;
    logic [PROD_W-1:0] p2_r;

    // Stage A: register the three full-width products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_r <= {PROD_W{1'b0}};
            p1_r <= {PROD_W{1'b0}};
            p2_r <= {PROD_W{1'b0}};
        end else begin
            p0_r <= PROD_W'(a0) * PROD_W'(b0);
            p1_r <= PROD_W'(a1) * PROD_W'(b1);
            p2_r <= PROD_W'(a2) * PROD_W'(b2);
        end
    end

    // Stage B: full SUM_W accumulation, then keep only the low element bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= {ELEM_W{1'b0}};
        end else begin
            sum <= ELEM_W'(SUM_W'(p0_r) + SUM_W'(p1_r) + SUM_W'(p2_r));
        end
    end

endmodule

// File: rtl/fast_matrix_mult_3x3.sv
// Pipelined R = A x B for 3x3 unsigned 8-bit matrices; result and valid_out follow start by 3 cycles.
module fast_matrix_mult_3x3
    import fast_matrix_mult_3x3_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MAT_W-1:0] matrix_a,
    input  logic [MAT_W-1:0] matrix_b,
    output logic [MAT_W-1:0] result,
    output logic             valid_out
);

    logic [MAT_W-1:0] a_r;
    logic [MAT_W-1:0] b_r;
    logic [2:0]       vld_r;
    logic [MAT_W-1:0] dot_s;

    // Operand latch: only a start edge loads new operands, so in-flight work is never disturbed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= {MAT_W{1'b0}};
            b_r <= {MAT_W{1'b0}};
        end else if (start) begin
            a_r <= matrix_a;
            b_r <= matrix_b;
        end else begin
            a_r <= a_r;
            b_r <= b_r;
        end
    end

    // Valid shift register tracking the operand latch and the two dot-product stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r     <= 3'b000;
            valid_out <= 1'b0;
        end else begin
            vld_r     <= {vld_r[1:0], start};
            valid_out <= vld_r[2];
        end
    end

    for (genvar i = 0; i < DIM; i++) begin : g_row
        for (genvar j = 0; j < DIM; j++) begin : g_col
            dot3_pipe u_dot (
                .clk   (clk),
                .rst_n (rst_n),
                .a0    (a_r[elem_lsb(i, 0) +: ELEM_W]),
                .a1    (a_r[elem_lsb(i, 1) +: ELEM_W]),
                .a2    (a_r[elem_lsb(i, 2) +: ELEM_W]),
                .b0    (b_r[elem_lsb(0, j) +: ELEM_W]),
                .b1    (b_r[elem_lsb(1, j) +: ELEM_W]),
                .b2    (b_r[elem_lsb(2, j) +: ELEM_W]),
                .sum   (dot_s[elem_lsb(i, j) +: ELEM_W])
            );
        end
    end

    // Output register: captures a new product only when a valid token leaves the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= {MAT_W{1'b0}};
        end else if (vld_r[2]) begin
            result <= dot_s;
        end else begin
            result <= result;
        end
    end

endmodule

// File: tb/tb_fast_matrix_mult_3x3.sv
// Randomized and directed bench for fast_matrix_mult_3x3 against a plain-arithmetic matrix model.
module tb_fast_matrix_mult_3x3;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [71:0] matrix_a;
    logic [71:0] matrix_b;
    logic [71:0] result;
    logic        valid_out;

    int err_cnt = 0;
    int chk_cnt = 0;
    int edge_cnt = 0;

    typedef struct {
        int          due;
        logic [71:0] res;
    } exp_t;

    exp_t        exp_q[$];
    logic [71:0] last_res = 72'h0;

    localparam logic [71:0] M_T1A  = 72'h010203040506070809;
    localparam logic [71:0] M_T1B  = 72'h090807060504030201;
    localparam logic [71:0] M_ID   = 72'h010000000100000001;
    localparam logic [71:0] M_ZERO = 72'h000000000000000000;
    localparam logic [71:0] M_ONES = 72'h010101010101010101;
    localparam logic [71:0] M_FF   = 72'hFFFFFFFFFFFFFFFFFF;

    fast_matrix_mult_3x3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .matrix_a  (matrix_a),
        .matrix_b  (matrix_b),
        .result    (result),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] mat_mult(input logic [71:0] a, input logic [71:0] b);
        logic [71:0] r;
        int s;
        r = 72'h0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++)
                    s += int'(a[71-8*(3*i+k) -: 8]) * int'(b[71-8*(3*k+j) -: 8]);
                r[71-8*(3*i+j) -: 8] = 8'(s % 256);
            end
        end
        return r;
    endfunction

    // Drive one cycle of stimulus, then check the outputs produced by that edge.
    task automatic cycle(input logic st, input logic [71:0] a, input logic [71:0] b);
        exp_t e;
        start    = st;
        matrix_a = a;
        matrix_b = b;
        @(posedge clk);
        edge_cnt++;
        if (st && rst_n) begin
            e.due = edge_cnt + 3;
            e.res = mat_mult(a, b);
            exp_q.push_back(e);
        end
        @(negedge clk);
        if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
            check_val("valid_pulse", {71'h0, valid_out}, 72'h1);
            check_val("result", result, exp_q[0].res);
            last_res = exp_q[0].res;
            void'(exp_q.pop_front());
        end else begin
            check_val("valid_idle", {71'h0, valid_out}, 72'h0);
            check_val("result_hold", result, last_res);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        matrix_a = 72'h0;
        matrix_b = 72'h0;

        check_val("model_t1", mat_mult(M_T1A, M_T1B), 72'h1E18125445368A725A);
        check_val("model_ff", mat_mult(M_FF, M_FF), 72'h030303030303030303);

        @(negedge clk);
        idle(10);
        rst_n = 1'b1;
        idle(20);

        cycle(1'b1, M_T1A, M_T1B);
        idle(5);
        cycle(1'b1, M_ID, M_T1B);
        idle(4);
        cycle(1'b1, M_ZERO, M_T1B);
        idle(4);
        cycle(1'b1, M_ONES, M_ONES);
        idle(4);
        cycle(1'b1, M_FF, M_FF);
        idle(4);

        cycle(1'b1, M_T1A, M_T1B);
        cycle(1'b1, M_ID, M_T1B);
        cycle(1'b1, M_ONES, M_ONES);
        idle(5);

        // Reset mid-flight: one start, then asynchronous reset one cycle later.
        cycle(1'b1, M_T1A, M_T1B);
        rst_n = 1'b0;
        #1;
        check_val("rst_valid", {71'h0, valid_out}, 72'h0);
        check_val("rst_result", result, 72'h0);
        exp_q.delete();
        last_res = 72'h0;
        @(negedge clk);
        idle(4);
        rst_n = 1'b1;
        idle(2);
        cycle(1'b1, M_ID, M_T1B);
        idle(4);

        for (int n = 0; n < 300; n++)
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
        idle(6);
        check_val("drain", 72'(exp_q.size()), 72'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
